// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned or out-of-range fetch addresses in adel_D.
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] NPC_in,
   input  logic [31:0] instr_F,
   input  logic        stall,
   input  logic        clr_D,
   output logic [31:0] PC_F,
   output logic [31:0] ADD4,
   output logic [31:0] IR_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC4_D,
   output logic        valid_D,
   output logic [31:0] fetch_cnt,
   output logic        adel_D
);

   localparam logic [31:0] ResetPc = 32'h0000_3000;

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_dec_q, pc_dec_d;
   logic [31:0] pc4_dec_q, pc4_dec_d;
   logic        valid_q, valid_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] add4;
   logic [31:0] fetch_ir;

   assign add4 = pc_f_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [31:0] TextLo = 32'h0000_3000;
   localparam logic [31:0] TextHi = 32'h0000_6FFC;

   logic adel_q, adel_d;
   logic addr_err;

   assign addr_err = (pc_f_q[1:0] != 2'b00) || (pc_f_q < TextLo) || (pc_f_q > TextHi);
   // A faulting fetch enters decode as a nop tagged with the error flag.
   assign fetch_ir = addr_err ? 32'h0 : instr_F;
`else
   assign fetch_ir = instr_F;
`endif

   always_comb begin
      pc_f_d    = pc_f_q;
      ir_d      = ir_q;
      pc_dec_d  = pc_dec_q;
      pc4_dec_d = pc4_dec_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_d    = adel_q;
`endif
      // stall outranks clr_D: everything holds while stalled.
      if (!stall) begin
         pc_f_d    = NPC_in;
         cnt_d     = cnt_q + 32'd1;
         pc_dec_d  = pc_f_q;
         pc4_dec_d = add4;
         if (clr_D) begin
            ir_d    = 32'h0;
            valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_d  = 1'b0;
`endif
         end else begin
            ir_d    = fetch_ir;
            valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_d  = addr_err;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f_q    <= ResetPc;
         ir_q      <= 32'h0;
         pc_dec_q  <= ResetPc;
         pc4_dec_q <= ResetPc + 32'd4;
         valid_q   <= 1'b0;
         cnt_q     <= 32'h0;
      end else begin
         pc_f_q    <= pc_f_d;
         ir_q      <= ir_d;
         pc_dec_q  <= pc_dec_d;
         pc4_dec_q <= pc4_dec_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adel_q <= 1'b0;
      end else begin
         adel_q <= adel_d;
      end
   end

   assign adel_D = adel_q;
`else
   assign adel_D = 1'b0;
`endif

   assign PC_F      = pc_f_q;
   assign ADD4      = add4;
   assign IR_D      = ir_q;
   assign PC_D      = pc_dec_q;
   assign PC4_D     = pc4_dec_q;
   assign valid_D   = valid_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, corner sequences and randomized
// stimulus checked against a behavioural model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] NPC_in;
   logic [31:0] instr_F;
   logic        stall;
   logic        clr_D;
   logic [31:0] PC_F;
   logic [31:0] ADD4;
   logic [31:0] IR_D;
   logic [31:0] PC_D;
   logic [31:0] PC4_D;
   logic        valid_D;
   logic [31:0] fetch_cnt;
   logic        adel_D;

   int n_cmp = 0;
   int n_err = 0;

   fetch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .NPC_in    (NPC_in),
      .instr_F   (instr_F),
      .stall     (stall),
      .clr_D     (clr_D),
      .PC_F      (PC_F),
      .ADD4      (ADD4),
      .IR_D      (IR_D),
      .PC_D      (PC_D),
      .PC4_D     (PC4_D),
      .valid_D   (valid_D),
      .fetch_cnt (fetch_cnt),
      .adel_D    (adel_D)
   );

   always #5 clk = ~clk;

   // Behavioural model of the architectural state.
   logic [31:0] m_pc, m_ir, m_pcd, m_cnt;
   logic        m_valid, m_adel;

   function automatic logic m_fault(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
      return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_pc = 32'h3000; m_ir = 32'h0; m_pcd = 32'h3000;
      m_cnt = 32'h0; m_valid = 1'b0; m_adel = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".PC_F"}, PC_F, m_pc);
      check({tag, ".ADD4"}, ADD4, m_pc + 32'd4);
      check({tag, ".IR_D"}, IR_D, m_ir);
      check({tag, ".PC_D"}, PC_D, m_pcd);
      check({tag, ".PC4_D"}, PC4_D, m_pcd + 32'd4);
      check({tag, ".valid_D"}, {31'b0, valid_D}, {31'b0, m_valid});
      check({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
      check({tag, ".adel_D"}, {31'b0, adel_D}, {31'b0, m_adel});
   endtask

   // Drive one cycle's inputs, advance the model, and land 1ns after the edge.
   task automatic step(input logic s, input logic c, input logic [31:0] npc,
                       input logic [31:0] ins);
      stall = s; clr_D = c; NPC_in = npc; instr_F = ins;
      if (!s) begin
         if (c) begin
            m_ir = 32'h0; m_valid = 1'b0; m_adel = 1'b0;
         end else begin
            m_adel  = m_fault(m_pc);
            m_ir    = m_adel ? 32'h0 : ins;
            m_valid = 1'b1;
         end
         m_pcd = m_pc;
         m_pc  = npc;
         m_cnt = m_cnt + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        s;
      logic        c;
      logic [31:0] npc;
      logic [31:0] instr;
      logic [31:0] pc_f;
      logic [31:0] pc_d;
      logic [31:0] ir;
      logic        v;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h3004, 32'h24010001, 32'h3004, 32'h3000, 32'h24010001, 1'b1, 32'd1};
      vecs[1] = '{1'b0, 1'b0, 32'h3008, 32'h24010001, 32'h3008, 32'h3004, 32'h24010001, 1'b1, 32'd2};
      vecs[2] = '{1'b0, 1'b0, 32'h300C, 32'h24010001, 32'h300C, 32'h3008, 32'h24010001, 1'b1, 32'd3};
      vecs[3] = '{1'b1, 1'b0, 32'h4000, 32'h11111111, 32'h300C, 32'h3008, 32'h24010001, 1'b1, 32'd3};
      vecs[4] = '{1'b1, 1'b0, 32'h4000, 32'h22222222, 32'h300C, 32'h3008, 32'h24010001, 1'b1, 32'd3};
      vecs[5] = '{1'b0, 1'b0, 32'h4000, 32'h33333333, 32'h4000, 32'h300C, 32'h33333333, 1'b1, 32'd4};
      vecs[6] = '{1'b1, 1'b1, 32'h4004, 32'h44444444, 32'h4000, 32'h300C, 32'h33333333, 1'b1, 32'd4};
      vecs[7] = '{1'b0, 1'b1, 32'h4004, 32'h55555555, 32'h4004, 32'h4000, 32'h00000000, 1'b0, 32'd5};
      vecs[8] = '{1'b0, 1'b0, 32'h4008, 32'h66666666, 32'h4008, 32'h4004, 32'h66666666, 1'b1, 32'd6};

      stall = 1'b0; clr_D = 1'b0; NPC_in = 32'h0; instr_F = 32'h0;
      reset = 1'b1;
      model_reset();
      #2;
      check_model("por");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      // Return to a clean reset state for the table.
      reset = 1'b1;
      #1;
      model_reset();
      check_model("reset_between_edges");
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         step(vecs[i].s, vecs[i].c, vecs[i].npc, vecs[i].instr);
         check($sformatf("vec%0d.PC_F", i), PC_F, vecs[i].pc_f);
         check($sformatf("vec%0d.ADD4", i), ADD4, vecs[i].pc_f + 32'd4);
         check($sformatf("vec%0d.PC_D", i), PC_D, vecs[i].pc_d);
         check($sformatf("vec%0d.PC4_D", i), PC4_D, vecs[i].pc_d + 32'd4);
         check($sformatf("vec%0d.IR_D", i), IR_D, vecs[i].ir);
         check($sformatf("vec%0d.valid_D", i), {31'b0, valid_D}, {31'b0, vecs[i].v});
         check($sformatf("vec%0d.fetch_cnt", i), fetch_cnt, vecs[i].cnt);
      end

      // Misaligned fetch address.
      step(1'b0, 1'b0, 32'h3002, 32'h77777777);
      check("align.PC_F", PC_F, 32'h3002);
      step(1'b0, 1'b0, 32'h3008, 32'h88888888);
      check("align.PC_D", PC_D, 32'h3002);
      check("align.valid_D", {31'b0, valid_D}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
      check("align.adel_D", {31'b0, adel_D}, 32'd1);
      check("align.IR_D", IR_D, 32'h0);
`else
      check("align.adel_D", {31'b0, adel_D}, 32'd0);
      check("align.IR_D", IR_D, 32'h88888888);
`endif
      check_model("align");

      // Counter wrap.
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      check("wrap.pre", fetch_cnt, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 32'h300C, 32'h12345678);
      check("wrap.fetch_cnt", fetch_cnt, 32'h0);
      step(1'b1, 1'b0, 32'h5000, 32'h0);
      check("wrap.hold", fetch_cnt, 32'h0);

      // Reset overriding an active stall and clear, then first fetch.
      stall = 1'b1; clr_D = 1'b1;
      reset = 1'b1;
      #1;
      model_reset();
      check_model("reset_mid_stall");
      @(negedge clk);
      check_model("reset_held");
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h3004, 32'hCAFE0001);
      check("first.PC_D", PC_D, 32'h3000);
      check("first.IR_D", IR_D, 32'hCAFE0001);
      check("first.valid_D", {31'b0, valid_D}, 32'd1);

      // Randomized stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         logic        s, c;
         logic [31:0] npc;
         int          sel;
         s   = ($urandom_range(0, 3) == 0);
         c   = ($urandom_range(0, 4) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 7)       npc = 32'h3000 + ($urandom_range(0, 4095) * 4);
         else if (sel == 7) npc = $urandom;
         else if (sel == 8) npc = ($urandom_range(0, 1) == 0) ? 32'h6FFC : 32'h7000;
         else               npc = ($urandom_range(0, 1) == 0) ? 32'h2FFC : 32'h3001;
         step(s, c, npc, $urandom);
         check_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
